// File: rtl/avalon_mem_responder.sv
// Avalon-MM slave word memory with configurable wait states and a fixed
// pipelined read latency; stands in for SDRAM in simulation and bring-up.
module avalon_mem_responder #(
    parameter int          DEPTH        = 256,
    parameter int          READ_LATENCY = 2,
    parameter int          WAIT_STATES  = 1,
    parameter logic [31:0] OOR_DATA     = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] slave_address,
    input  logic        slave_read,
    input  logic        slave_write,
    input  logic [31:0] slave_writedata,
    output logic        slave_waitrequest,
    output logic [31:0] slave_readdata,
    output logic        slave_readdatavalid,
    output logic [7:0]  err_count
);

    // Handshake: a command is accepted on a rising edge where slave_read or
    // slave_write is high and slave_waitrequest is low; while waitrequest is
    // high the master must hold the command. Read data is returned on the
    // one-cycle slave_readdatavalid pulse, in acceptance order, with no
    // backpressure.

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {
        ACCEPT = 1'b0,
        STALL  = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  stall_cnt;
    logic [3:0]  stall_cnt_next;

    logic [31:0] mem [DEPTH];

    logic [29:0] word_idx;
    logic [AW-1:0] mem_idx;
    logic        in_range;
    logic        cmd_accept;
    logic        wr_mem;
    logic        rd_accept;
    logic        err_event;
    logic [31:0] rd_snap;
    logic        unused_addr_bits;

    logic [READ_LATENCY-1:0] pipe_valid;
    logic [READ_LATENCY:0]   valid_shift;
    logic [31:0]             pipe_data [READ_LATENCY];

    assign word_idx         = slave_address[31:2];
    assign mem_idx          = slave_address[AW+1:2];
    assign in_range         = word_idx < 30'(DEPTH);
    assign unused_addr_bits = ^slave_address[1:0];

    assign cmd_accept = (state == ACCEPT) && (slave_read || slave_write);
    assign wr_mem     = cmd_accept && slave_write && in_range;
    // A simultaneous read and write keeps the write and drops the read.
    assign rd_accept  = cmd_accept && slave_read && !slave_write;
    assign err_event  = cmd_accept && ((slave_read && slave_write) || !in_range);
    assign rd_snap    = in_range ? mem[mem_idx] : OOR_DATA;

    assign slave_waitrequest = (state == STALL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ACCEPT;
            stall_cnt <= '0;
        end else begin
            state     <= state_next;
            stall_cnt <= stall_cnt_next;
        end
    end

    always_comb begin
        state_next     = state;
        stall_cnt_next = stall_cnt;
        case (state)
            ACCEPT: begin
                if (cmd_accept && (WAIT_STATES > 0)) begin
                    state_next     = STALL;
                    stall_cnt_next = 4'(WAIT_STATES - 1);
                end
            end
            STALL: begin
                if (stall_cnt == 4'd0) begin
                    state_next = ACCEPT;
                end else begin
                    stall_cnt_next = stall_cnt - 4'd1;
                end
            end
        endcase
    end

    // Storage is deliberately outside reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (wr_mem) begin
            mem[mem_idx] <= slave_writedata;
        end
    end

    assign valid_shift = {pipe_valid, rd_accept};

    // Data stages only load when a valid entry moves in, so the last stage
    // keeps presenting the most recently delivered word between pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_valid <= '0;
            for (int k = 0; k < READ_LATENCY; k++) begin
                pipe_data[k] <= '0;
            end
        end else begin
            pipe_valid <= valid_shift[READ_LATENCY-1:0];
            if (rd_accept) begin
                pipe_data[0] <= rd_snap;
            end
            for (int k = 1; k < READ_LATENCY; k++) begin
                if (pipe_valid[k-1]) begin
                    pipe_data[k] <= pipe_data[k-1];
                end
            end
        end
    end

    assign slave_readdatavalid = pipe_valid[READ_LATENCY-1];
    assign slave_readdata      = pipe_data[READ_LATENCY-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= '0;
        end else if (err_event && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_avalon_mem_responder.sv
// Bench for avalon_mem_responder: a default-parameter instance exercised with
// directed and random traffic, plus a zero-wait, latency-3 instance.
module tb_avalon_mem_responder;

    localparam int          DEPTH    = 256;
    localparam int          RL       = 2;
    localparam logic [31:0] OOR      = 32'hDEADBEEF;
    localparam int          F_DEPTH  = 64;
    localparam int          F_RL     = 3;

    logic        clk;
    logic        rst;
    logic [31:0] slave_address;
    logic        slave_read;
    logic        slave_write;
    logic [31:0] slave_writedata;
    logic        slave_waitrequest;
    logic [31:0] slave_readdata;
    logic        slave_readdatavalid;
    logic [7:0]  err_count;

    logic [31:0] f_address;
    logic        f_read;
    logic        f_write;
    logic [31:0] f_writedata;
    logic        f_waitrequest;
    logic [31:0] f_readdata;
    logic        f_readdatavalid;
    logic [7:0]  f_err_count;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: word array, expected read queues with due cycles.
    logic [31:0] model_mem [DEPTH];
    logic [31:0] fmodel    [F_DEPTH];
    int          model_err = 0;
    logic [31:0] exp_q  [$];
    int          due_q  [$];
    logic [31:0] fexp_q [$];
    int          fdue_q [$];

    avalon_mem_responder #(
        .DEPTH(DEPTH), .READ_LATENCY(RL), .WAIT_STATES(1), .OOR_DATA(OOR)
    ) u_dut (
        .clk(clk), .rst(rst),
        .slave_address(slave_address), .slave_read(slave_read),
        .slave_write(slave_write), .slave_writedata(slave_writedata),
        .slave_waitrequest(slave_waitrequest), .slave_readdata(slave_readdata),
        .slave_readdatavalid(slave_readdatavalid), .err_count(err_count)
    );

    avalon_mem_responder #(
        .DEPTH(F_DEPTH), .READ_LATENCY(F_RL), .WAIT_STATES(0), .OOR_DATA(OOR)
    ) u_fast (
        .clk(clk), .rst(rst),
        .slave_address(f_address), .slave_read(f_read),
        .slave_write(f_write), .slave_writedata(f_writedata),
        .slave_waitrequest(f_waitrequest), .slave_readdata(f_readdata),
        .slave_readdatavalid(f_readdatavalid), .err_count(f_err_count)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Driver for the default instance: hold the command until accepted.
    task automatic bus_cmd(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] data);
        int          waited;
        logic [29:0] idx;
        logic        oor;
        waited = 0;
        @(negedge clk);
        slave_read = rd; slave_write = wr;
        slave_address = addr; slave_writedata = data;
        while (slave_waitrequest !== 1'b0 && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 64) begin
            checks++;
            errors++;
            $error("FAIL accept_timeout observed waitrequest %b expected 0", slave_waitrequest);
            slave_read = 1'b0; slave_write = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        slave_read = 1'b0; slave_write = 1'b0;
        idx = addr[31:2];
        oor = (idx >= 30'(DEPTH));
        if (wr && !oor) model_mem[idx[7:0]] = data;
        if (rd && !wr) begin
            exp_q.push_back(oor ? OOR : model_mem[idx[7:0]]);
            due_q.push_back(cyc + RL - 1);
        end
        if (((rd && wr) || oor) && model_err < 255) model_err++;
    endtask

    // Driver for the fast instance: one command per cycle, never stalled.
    task automatic f_cmd(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] data);
        logic [29:0] idx;
        @(negedge clk);
        f_read = rd; f_write = wr; f_address = addr; f_writedata = data;
        check32("fast_waitrequest", {31'b0, f_waitrequest}, 32'd0);
        @(posedge clk);
        #1;
        idx = addr[31:2];
        if (rd && !wr) begin
            fexp_q.push_back(fmodel[idx[5:0]]);
            fdue_q.push_back(cyc + F_RL - 1);
        end
        if (wr) fmodel[idx[5:0]] = data;
    endtask

    // Scoreboards: every readdatavalid pulse must match the head of its queue.
    always @(negedge clk) begin
        if (slave_readdatavalid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_rdv observed data %h expected no pulse", slave_readdata);
            end else begin
                check32("rd_data", slave_readdata, exp_q.pop_front());
                check32("rd_cycle", 32'(cyc), 32'(due_q.pop_front()));
            end
        end
        if (f_readdatavalid === 1'b1) begin
            if (fexp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL fast_unexpected_rdv observed data %h expected no pulse", f_readdata);
            end else begin
                check32("fast_rd_data", f_readdata, fexp_q.pop_front());
                check32("fast_rd_cycle", 32'(cyc), 32'(fdue_q.pop_front()));
            end
        end
    end

    initial begin
        logic [31:0] d;
        int          op;
        int          w;

        rst = 1'b1;
        slave_address = '0; slave_read = 1'b0; slave_write = 1'b0; slave_writedata = '0;
        f_address = '0; f_read = 1'b0; f_write = 1'b0; f_writedata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check32("reset_waitreq", {31'b0, slave_waitrequest}, 32'd0);
        check32("reset_rdv", {31'b0, slave_readdatavalid}, 32'd0);
        check32("reset_rdata", slave_readdata, 32'd0);
        check32("reset_err", {24'b0, err_count}, 32'd0);

        // Write then read word 13, with one wait state after each command.
        bus_cmd(1'b0, 1'b1, 32'd52, 32'hCDDDEEEF);
        @(negedge clk);
        check32("stall_after_write", {31'b0, slave_waitrequest}, 32'd1);
        @(negedge clk);
        check32("accept_after_stall", {31'b0, slave_waitrequest}, 32'd0);
        bus_cmd(1'b1, 1'b0, 32'd52, 32'h0);
        @(negedge clk);
        check32("stall_after_read", {31'b0, slave_waitrequest}, 32'd1);
        repeat (3) @(negedge clk);
        check32("rdata_hold", slave_readdata, 32'hCDDDEEEF);

        // Out-of-range read, write, and read+write collision.
        bus_cmd(1'b1, 1'b0, 32'(4 * DEPTH), 32'h0);
        repeat (3) @(negedge clk);
        check32("err_oor_read", {24'b0, err_count}, 32'd1);
        bus_cmd(1'b0, 1'b1, 32'(4 * DEPTH), 32'h12345678);
        repeat (2) @(negedge clk);
        check32("err_oor_write", {24'b0, err_count}, 32'd2);
        bus_cmd(1'b1, 1'b1, 32'd80, 32'hA5A5F00D);
        repeat (3) @(negedge clk);
        check32("err_rd_wr", {24'b0, err_count}, 32'd3);
        bus_cmd(1'b1, 1'b0, 32'd80, 32'h0);
        bus_cmd(1'b1, 1'b0, 32'd52, 32'h0);

        // Random traffic over words 0..31, with occasional error cases.
        for (int i = 0; i < 32; i++) begin
            bus_cmd(1'b0, 1'b1, {22'd0, 8'(i), 2'($urandom)}, $urandom);
        end
        for (int i = 0; i < 80; i++) begin
            op = $urandom_range(0, 9);
            w  = $urandom_range(0, 31);
            d  = $urandom;
            if (op <= 4)      bus_cmd(1'b1, 1'b0, {22'd0, 8'(w), 2'($urandom)}, 32'h0);
            else if (op <= 6) bus_cmd(1'b0, 1'b1, {22'd0, 8'(w), 2'($urandom)}, d);
            else if (op == 7) bus_cmd(1'b1, 1'b0, 32'((DEPTH + $urandom_range(0, 5000)) * 4), 32'h0);
            else if (op == 8) bus_cmd(1'b0, 1'b1, 32'((DEPTH + $urandom_range(0, 5000)) * 4), d);
            else              bus_cmd(1'b1, 1'b1, {22'd0, 8'(w), 2'b00}, d);
        end
        repeat (4) @(negedge clk);
        check32("err_random", {24'b0, err_count}, 32'(model_err));

        // Reset with a read in flight: the response must be dropped.
        bus_cmd(1'b1, 1'b0, 32'd52, 32'h0);
        rst = 1'b1;
        exp_q.delete();
        due_q.delete();
        model_err = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check32("rst_mid_waitreq", {31'b0, slave_waitrequest}, 32'd0);
        check32("rst_mid_err", {24'b0, err_count}, 32'd0);
        check32("rst_mid_rdv", {31'b0, slave_readdatavalid}, 32'd0);
        repeat (4) @(negedge clk);
        bus_cmd(1'b1, 1'b0, 32'd52, 32'h0);
        bus_cmd(1'b1, 1'b0, 32'd4, 32'h0);

        // Error counter saturation.
        for (int i = 0; i < 300; i++) begin
            bus_cmd(1'b1, 1'b0, 32'((DEPTH + i) * 4), 32'h0);
        end
        repeat (4) @(negedge clk);
        check32("err_saturate", {24'b0, err_count}, 32'd255);

        // Fast instance: back-to-back writes, reads, and write in the read window.
        for (int i = 0; i < 5; i++) f_cmd(1'b0, 1'b1, 32'((13 + i) * 4), 32'(i + 1));
        f_cmd(1'b0, 1'b1, 32'd20, 32'd7);
        for (int i = 0; i < 5; i++) f_cmd(1'b1, 1'b0, 32'((13 + i) * 4), 32'h0);
        f_cmd(1'b1, 1'b0, 32'd20, 32'h0);
        f_cmd(1'b0, 1'b1, 32'd20, 32'd9);
        f_cmd(1'b1, 1'b0, 32'd20, 32'h0);
        @(negedge clk);
        f_read = 1'b0; f_write = 1'b0;
        repeat (6) @(negedge clk);
        check32("fast_err", {24'b0, f_err_count}, 32'd0);

        repeat (4) @(negedge clk);
        check32("drained", 32'(exp_q.size()), 32'd0);
        check32("fast_drained", 32'(fexp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
